// File: rtl/gate_sweep_ctrl.sv
// Stimulus sequencer and on-chip checker for a 2-input combinational gate:
// walks 00,01,10,11 with a programmable hold, samples the gate and grades it.
module gate_sweep_ctrl #(
    parameter int unsigned HOLD_CYCLES = 250,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] exp_tt,
    input  logic       gate_o,
    output logic       i0,
    output logic       i1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] obs_tt,
    output logic [3:0] err_mask
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    // Bitwise disagreement between observed and expected truth tables.
    function automatic logic [3:0] tt_diff(input logic [3:0] obs, input logic [3:0] expd);
        return obs ^ expd;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       exp_cap_q, exp_cap_d;
    logic [3:0]       obs_q, obs_d;
    logic [3:0]       err_q, err_d;
    logic             pass_q, pass_d;
    logic             i0_q, i0_d;
    logic             i1_q, i1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, sweep bookkeeping and registered-output precomputation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        exp_cap_d = exp_cap_q;
        obs_d     = obs_q;
        err_d     = err_q;
        pass_d    = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_cap_d = exp_tt;
                    obs_d     = 4'b0000;
                    err_d     = 4'b0000;
                    pass_d    = 1'b0;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                    state_d   = ST_DRIVE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    obs_d[idx_q] = gate_o;
                    if (idx_q == 2'd3) begin
                        // Grade using the table including the bit captured this edge,
                        // so pass/err_mask are already valid alongside done.
                        state_d = ST_DONE;
                        idx_d   = 2'd0;
                        pass_d  = (obs_d == exp_cap_q);
                        err_d   = tt_diff(obs_d, exp_cap_q);
                    end else begin
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRIVE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DRIVE) begin
            i0_d = idx_d[1];
            i1_d = idx_d[0];
        end else begin
            i0_d = 1'b0;
            i1_d = 1'b0;
        end
    end

    // State and output registers; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            exp_cap_q <= 4'b0000;
            obs_q     <= 4'b0000;
            err_q     <= 4'b0000;
            pass_q    <= 1'b0;
            i0_q      <= 1'b0;
            i1_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            exp_cap_q <= exp_cap_d;
            obs_q     <= obs_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            i0_q      <= i0_d;
            i1_q      <= i1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign i0       = i0_q;
    assign i1       = i1_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign obs_tt   = obs_q;
    assign err_mask = err_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: a HOLD=250 instance driving a selectable
// gate model and a HOLD=1 instance driving an XOR.
module tb_gate_sweep_ctrl;

    localparam int H = 250;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [3:0] exp0, exp1;
    logic       g0, g1;
    logic [1:0] gate_sel;

    logic       d0_i0, d0_i1, d0_busy, d0_done, d0_pass;
    logic [3:0] d0_obs, d0_err;
    logic       d1_i0, d1_i1, d1_busy, d1_done, d1_pass;
    logic [3:0] d1_obs, d1_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gate_sweep_ctrl #(.HOLD_CYCLES(H), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .exp_tt(exp0), .gate_o(g0),
        .i0(d0_i0), .i1(d0_i1), .busy(d0_busy), .done(d0_done), .pass(d0_pass),
        .obs_tt(d0_obs), .err_mask(d0_err)
    );

    gate_sweep_ctrl #(.HOLD_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_tt(exp1), .gate_o(g1),
        .i0(d1_i0), .i1(d1_i1), .busy(d1_busy), .done(d1_done), .pass(d1_pass),
        .obs_tt(d1_obs), .err_mask(d1_err)
    );

    // Gate models: 0 = NAND, 1 = AND, other = stuck-at-0.
    always_comb begin
        case (gate_sel)
            2'd0:    g0 = ~(d0_i0 & d0_i1);
            2'd1:    g0 = d0_i0 & d0_i1;
            default: g0 = 1'b0;
        endcase
    end
    assign g1 = d1_i0 ^ d1_i1;

    typedef struct {
        logic [3:0] expt;
        logic [1:0] gsel;
        logic [3:0] obs;
        logic       pass;
        logic [3:0] err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Runs one full sweep on dut0 from an IDLE negedge through the first IDLE
    // cycle afterwards, checking i0/i1/busy/done cycle by cycle.
    task automatic sweep0(input logic [3:0] expt, input logic [1:0] gsel,
                          input int extra_start, input int chg_cyc, input bit hold_start,
                          output int bad, output int done_cnt,
                          output logic [3:0] obs_r, output logic pass_r, output logic [3:0] err_r);
        logic [1:0] ev;
        bit         eb, ed;
        gate_sel = gsel;
        exp0     = expt;
        start0   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start0 = 1'b0;
        bad = 0; done_cnt = 0; obs_r = 4'hx; pass_r = 1'bx; err_r = 4'hx;
        for (int c = 1; c <= 4*H+2; c++) begin
            @(negedge clk);
            start0 = (hold_start || (c == extra_start)) ? 1'b1 : 1'b0;
            if (c == chg_cyc) exp0 = 4'b0000;
            eb = (c >= 1 && c <= 4*H);
            ed = (c == 4*H+1);
            ev = eb ? 2'((c-1)/H) : 2'd0;
            if ({d0_i0, d0_i1} !== ev || d0_busy !== eb || d0_done !== ed) bad++;
            if (c == 1 && (d0_obs !== 4'b0000 || d0_pass !== 1'b0 || d0_err !== 4'b0000)) bad++;
            if (d0_done === 1'b1) begin
                done_cnt++;
                obs_r = d0_obs; pass_r = d0_pass; err_r = d0_err;
            end
            if (c == 4*H+2 && (d0_obs !== obs_r || d0_pass !== pass_r || d0_err !== err_r)) bad++;
        end
    endtask

    task automatic check_sweep(input string tag, input int bad, input int dcnt,
                               input logic [3:0] o, input logic p, input logic [3:0] e,
                               input logic [3:0] eo, input logic ep, input logic [3:0] ee);
        chk({tag, "_timing"}, 32'(bad), 32'd0);
        chk({tag, "_done_cnt"}, 32'(dcnt), 32'd1);
        chk({tag, "_obs"}, 32'(o), 32'(eo));
        chk({tag, "_pass"}, 32'(p), 32'(ep));
        chk({tag, "_err"}, 32'(e), 32'(ee));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bad, dcnt;
        logic [3:0] o, e;
        logic       p;

        vecs[0] = '{expt: 4'b0111, gsel: 2'd0, obs: 4'b0111, pass: 1'b1, err: 4'b0000};
        vecs[1] = '{expt: 4'b1000, gsel: 2'd0, obs: 4'b0111, pass: 1'b0, err: 4'b1111};
        vecs[2] = '{expt: 4'b0111, gsel: 2'd1, obs: 4'b1000, pass: 1'b0, err: 4'b1111};
        vecs[3] = '{expt: 4'b1000, gsel: 2'd1, obs: 4'b1000, pass: 1'b1, err: 4'b0000};
        vecs[4] = '{expt: 4'b0011, gsel: 2'd0, obs: 4'b0111, pass: 1'b0, err: 4'b0100};
        vecs[5] = '{expt: 4'b0111, gsel: 2'd2, obs: 4'b0000, pass: 1'b0, err: 4'b0111};

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        exp0 = 4'b0000; exp1 = 4'b0000; gate_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_d0", 32'({d0_i0, d0_i1, d0_busy, d0_done, d0_pass, d0_obs, d0_err}), 32'd0);
        chk("reset_d1", 32'({d1_i0, d1_i1, d1_busy, d1_done, d1_pass, d1_obs, d1_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            sweep0(vecs[v].expt, vecs[v].gsel, 0, 0, 1'b0, bad, dcnt, o, p, e);
            check_sweep($sformatf("vec%0d", v), bad, dcnt, o, p, e,
                        vecs[v].obs, vecs[v].pass, vecs[v].err);
        end

        // Start pulse and expected-table change mid-sweep must not disturb it.
        sweep0(4'b0111, 2'd0, 300, 300, 1'b0, bad, dcnt, o, p, e);
        check_sweep("midchg", bad, dcnt, o, p, e, 4'b0111, 1'b1, 4'b0000);

        // Start held high: re-accepted on the first IDLE cycle (inner checks
        // of the second sweep cover busy and cleared pass on its cycle 1).
        sweep0(4'b0111, 2'd0, 0, 0, 1'b1, bad, dcnt, o, p, e);
        check_sweep("held1", bad, dcnt, o, p, e, 4'b0111, 1'b1, 4'b0000);
        sweep0(4'b0111, 2'd0, 0, 0, 1'b0, bad, dcnt, o, p, e);
        check_sweep("held2", bad, dcnt, o, p, e, 4'b0111, 1'b1, 4'b0000);

        // HOLD_CYCLES = 1 with an XOR gate.
        begin
            int d1bad, d1dn;
            logic       eb, ed;
            logic [1:0] ev;
            exp1 = 4'b0110; start1 = 1'b1;
            @(posedge clk);
            #1 start1 = 1'b0;
            d1bad = 0; d1dn = 0;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                eb = (c >= 1 && c <= 4);
                ed = (c == 5);
                ev = eb ? 2'(c-1) : 2'd0;
                if ({d1_i0, d1_i1} !== ev || d1_busy !== eb || d1_done !== ed) d1bad++;
                if (c == 5) begin
                    d1dn++;
                    o = d1_obs; p = d1_pass; e = d1_err;
                end
            end
            check_sweep("hold1", d1bad, d1dn, o, p, e, 4'b0110, 1'b1, 4'b0000);
        end

        // Reset mid-sweep at cycle 400, release at 410, restart at 420.
        begin
            int rbad;
            gate_sel = 2'd0; exp0 = 4'b0111; start0 = 1'b1;
            @(posedge clk);
            #1 start0 = 1'b0;
            for (int c = 1; c <= 400; c++) @(negedge clk);
            chk("partial_obs", 32'(d0_obs), 32'd1);
            chk("partial_vec", 32'({d0_i0, d0_i1, d0_busy}), 32'b011);
            rst_n = 1'b0;
            #1;
            chk("rst_async", 32'({d0_i0, d0_i1, d0_busy, d0_done, d0_pass, d0_obs, d0_err}), 32'd0);
            rbad = 0;
            for (int c = 401; c <= 420; c++) begin
                @(negedge clk);
                if (d0_done !== 1'b0 || d0_busy !== 1'b0) rbad++;
                if (c == 410) rst_n = 1'b1;
            end
            chk("rst_no_done", 32'(rbad), 32'd0);
            sweep0(4'b0111, 2'd0, 0, 0, 1'b0, bad, dcnt, o, p, e);
            check_sweep("after_rst", bad, dcnt, o, p, e, 4'b0111, 1'b1, 4'b0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
